// File: rtl/char_stream_fifo.sv
// Character FIFO feeding Character_FSM: valid/ready write side, registered byte output.
// Optional macro CHAR_FSM_CASE_FOLD_EN folds 'a'..'z' to upper case as bytes reach out_char.
`timescale 1ns/1ps

module char_stream_fifo #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [7:0]               out_char,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign wr_ready = (count != FULL_CNT);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && (count != '0);

`ifdef CHAR_FSM_CASE_FOLD_EN
  // Only lowercase letters lose bit 5; IDLE_CHAR never passes through here.
  assign head = (mem[rd_ptr] >= 8'h61 && mem[rd_ptr] <= 8'h7A) ?
                {mem[rd_ptr][7:6], 1'b0, mem[rd_ptr][4:0]} : mem[rd_ptr];
`else
  assign head = mem[rd_ptr];
`endif

  // Storage needs no reset: reset zeroes the pointers, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_char  <= IDLE_CHAR;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (wr_valid && !wr_ready) overflow <= 1'b1;

      // The pop sees occupancy before this edge's write, so there is no bypass path.
      if (rd_en) begin
        if (pop) begin
          out_char  <= head;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          out_char  <= IDLE_CHAR;
          out_valid <= 1'b0;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_fifo.sv
// Scoreboard bench for char_stream_fifo: stimulus queues expected bytes, a monitor checks out_char.
`timescale 1ns/1ps

module tb_char_stream_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       rd_en = 1'b0;
  logic [7:0] out_char;
  logic       out_valid;
  logic [3:0] count;
  logic       overflow;

  int total = 0;
  int bad = 0;
  logic [7:0] expq [$];

  char_stream_fifo #(.DEPTH(8), .IDLE_CHAR(8'h00)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_en(rd_en), .out_char(out_char),
    .out_valid(out_valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; if acc, the byte should be taken and exp should later appear.
  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic r,
                               input logic acc, input logic [7:0] e);
    @(posedge clk);
    #1;
    wr_data  = d;
    wr_valid = v;
    rd_en    = r;
    if (v) checkOutput("wr_ready", wr_ready, acc);
    if (v && acc) expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, r, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst out_char", out_char, 8'h00);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst count", count, 0);
    checkOutput("rst overflow", overflow, 0);
    reset = 1'b0;
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, expq.size(), 0);
  endtask

  // Monitor: compares only on edges where rd_en advanced the output register.
  initial begin
    logic adv;
    forever begin
      @(posedge clk);
      adv = rd_en && !reset;
      @(negedge clk);
      if (adv) begin
        if (out_valid) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected byte: got %0h, expected none at %0t", out_char, $time);
          end else begin
            checkOutput("out_char", out_char, expq.pop_front());
          end
        end else begin
          checkOutput("idle char", out_char, 8'h00);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8*4-1:0] s4;
    logic [8*5-1:0] s5;
    logic [8*5-1:0] e5;

    doReset();

    // Test 1: free-running consumer, output one edge behind push
    s4 = "#BUA";
    for (int i = 0; i < 4; i++) applyStimulus(s4[31-8*i -: 8], 1'b1, 1'b1, 1'b1, s4[31-8*i -: 8]);
    idle(3, 1'b1);
    checkOutput("t1 out_valid low", out_valid, 0);
    checkOutput("t1 out_char idle", out_char, 8'h00);
    checkDrained("t1 drained");

    // Test 2: fill to full, overflow drops ninth byte
    for (int i = 0; i < 8; i++) applyStimulus(8'h30 + 8'(i), 1'b1, 1'b0, 1'b1, 8'h30 + 8'(i));
    applyStimulus(8'h38, 1'b1, 1'b0, 1'b0, 8'h38);
    checkOutput("t2 count full", count, 8);
    checkOutput("t2 overflow before", overflow, 0);
    idle(1, 1'b0);
    checkOutput("t2 overflow set", overflow, 1);
    checkOutput("t2 count held", count, 8);
    idle(10, 1'b1);
    checkDrained("t2 drained");
    checkOutput("t2 count empty", count, 0);

    // Test 3: steady push+pop at occupancy 5 across pointer wrap
    for (int i = 0; i < 5; i++) applyStimulus(8'h40 + 8'(i), 1'b1, 1'b0, 1'b1, 8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h45 + 8'(i), 1'b1, 1'b1, 1'b1, 8'h45 + 8'(i));
      checkOutput("t3 count steady", count, 5);
    end
    idle(8, 1'b1);
    checkDrained("t3 drained");
    checkOutput("t3 overflow sticky", overflow, 1);

    // Test 4: asynchronous reset mid-stream
    s4 = "BUAA";
    for (int i = 0; i < 4; i++) applyStimulus(s4[31-8*i -: 8], 1'b1, 1'b0, 1'b1, s4[31-8*i -: 8]);
    idle(3, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t4 async out_char", out_char, 8'h00);
    checkOutput("t4 async out_valid", out_valid, 0);
    checkOutput("t4 async count", count, 0);
    checkOutput("t4 pending A A", expq.size(), 2);
    doReset();
    idle(5, 1'b1);
    checkDrained("t4 nothing after reset");

    // Test 5: case folding depends on build macro
    s5 = "buaA?";
`ifdef CHAR_FSM_CASE_FOLD_EN
    e5 = "BUAA?";
`else
    e5 = "buaA?";
`endif
    for (int i = 0; i < 5; i++) applyStimulus(s5[39-8*i -: 8], 1'b1, 1'b1, 1'b1, e5[39-8*i -: 8]);
    idle(3, 1'b1);
    checkDrained("t5 drained");

    // Test 6: rd_en low holds the output register
    applyStimulus("Q", 1'b1, 1'b1, 1'b1, "Q");
    idle(1, 1'b1);
    applyStimulus("X", 1'b1, 1'b0, 1'b1, "X");
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      checkOutput("t6 hold char", out_char, "Q");
      checkOutput("t6 hold valid", out_valid, 1);
    end
    idle(3, 1'b1);
    checkDrained("t6 drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
